// File: rtl/gcd_fsmd_param.sv
// WIDTH-bit GCD engine (controller FSM + subtract datapath), start/ready in, one-cycle done out.
// Define GCD_ITER_COUNT_EN to add the saturating iter_count output.
module gcd_fsmd_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             ready,
   output logic             done,
`ifdef GCD_ITER_COUNT_EN
   output logic [CNT_W-1:0] iter_count,
`endif
   output logic [WIDTH-1:0] gcd_out
);

   if (WIDTH < 2 || CNT_W < 1) begin : g_bad_param
      $error("gcd_fsmd_param: WIDTH must be >= 2 and CNT_W >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic             a_lt_b, a_eq_b, any_zero;
   logic [WIDTH-1:0] diff;

`ifdef GCD_ITER_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction
`endif

   // One shared subtractor: always larger minus smaller, so it cannot underflow
   assign a_lt_b   = (a_q < b_q);
   assign a_eq_b   = (a_q == b_q);
   assign any_zero = (a_q == '0) || (b_q == '0);
   assign diff     = a_lt_b ? (b_q - a_q) : (a_q - b_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
`ifdef GCD_ITER_COUNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
`ifdef GCD_ITER_COUNT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CALC;
         S_CALC:  if (any_zero || a_eq_b) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      gcd_d = gcd_q;
`ifdef GCD_ITER_COUNT_EN
      cnt_d = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d = a_in;
               b_d = b_in;
`ifdef GCD_ITER_COUNT_EN
               cnt_d = '0;
`endif
            end
         end
         S_CALC: begin
            if (any_zero) begin
               gcd_d = a_q | b_q;
            end else if (a_eq_b) begin
               gcd_d = a_q;
            end else begin
               if (a_lt_b) b_d = diff;
               else        a_d = diff;
`ifdef GCD_ITER_COUNT_EN
               cnt_d = sat_inc(cnt_q);
`endif
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      ready   = (state_q == S_IDLE);
      done    = (state_q == S_DONE);
      gcd_out = gcd_q;
`ifdef GCD_ITER_COUNT_EN
      iter_count = cnt_q;
`endif
   end

endmodule

// File: tb/tb_gcd_fsmd_param.sv
// Directed + random bench for gcd_fsmd_param with a queue scoreboard and a Euclid reference model.
module tb_gcd_fsmd_param;
   localparam int WIDTH = 8;
   localparam int CNT_W = 16;
   localparam int BUDGET = (1 << WIDTH) + 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a_in, b_in;
   logic             ready, done;
   logic [WIDTH-1:0] gcd_out;
`ifdef GCD_ITER_COUNT_EN
   logic [CNT_W-1:0] iter_count;
`endif

   always #5 clk = ~clk;

   gcd_fsmd_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .ready(ready), .done(done),
`ifdef GCD_ITER_COUNT_EN
      .iter_count(iter_count),
`endif
      .gcd_out(gcd_out)
   );

   typedef struct { int g; int n; } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int glitch_cnt = 0;
   logic [WIDTH-1:0] last_gcd = '0;

   // gcd_out may only move in the cycle where done is high
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (!rst && !done && gcd_out !== last_gcd) glitch_cnt <= glitch_cnt + 1;
      last_gcd <= gcd_out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Euclid by division; subtract-step count is the sum of quotients minus one
   function automatic exp_t ref_gcd(input int a, input int b);
      exp_t r;
      int x, y, t, qs;
      x = a; y = b; qs = 0;
      while (y != 0) begin
         qs += x / y;
         t = x % y;
         x = y;
         y = t;
      end
      r.g = x;
      r.n = (a == 0 || b == 0) ? 0 : qs - 1;
      return r;
   endfunction

   task automatic do_start(input int a, input int b);
      @(negedge clk);
      a_in = WIDTH'(a);
      b_in = WIDTH'(b);
      start = 1'b1;
      if (ready) sb.push_back(ref_gcd(a, b));
      @(negedge clk);
      start = 1'b0;
      a_in = WIDTH'($urandom);
      b_in = WIDTH'($urandom);
   endtask

   // Entered at the negedge of cycle lat0 after the accept edge
   task automatic wait_done(input string tag, input int lat0);
      int lat, d0;
      exp_t e;
      #1;
      d0 = done_cnt;
      lat = lat0;
      while (!done && lat < BUDGET) begin
         chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         chk({tag, "_timeout"}, 32'(lat), 32'(BUDGET - 1));
         return;
      end
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_gcd"}, 32'(gcd_out), 32'(e.g));
      chk({tag, "_latency"}, 32'(lat), 32'(e.n + 2));
`ifdef GCD_ITER_COUNT_EN
      chk({tag, "_iter"}, 32'(iter_count), 32'(e.n));
`endif
      @(negedge clk);
      #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_ready_after"}, 32'(ready), 32'd1);
      chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int d0;
      rst = 1'b1;
      start = 1'b0;
      a_in = '0;
      b_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_gcd", 32'(gcd_out), 32'd0);
      rst = 1'b0;

      do_start(12, 18);  wait_done("t1_12_18", 1);
      do_start(7, 7);    wait_done("t2_7_7", 1);
      do_start(0, 9);    wait_done("t2_0_9", 1);
      do_start(9, 0);    wait_done("t2_9_0", 1);
      do_start(0, 0);    wait_done("t2_0_0", 1);
      do_start(255, 1);  wait_done("t3_255_1", 1);
      do_start(128, 96); wait_done("t3_128_96", 1);

      // Start pulse while busy must be ignored
      do_start(12, 18);
      a_in = 8'd5;
      b_in = 8'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t4_ignored", 2);
      do_start(5, 10);   wait_done("t4_fresh", 1);

      // Asynchronous reset mid-calculation
      do_start(255, 1);
      repeat (48) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_ready", 32'(ready), 32'd1);
      chk("t5_rst_done", 32'(done), 32'd0);
      chk("t5_rst_gcd", 32'(gcd_out), 32'd0);
`ifdef GCD_ITER_COUNT_EN
      chk("t5_rst_iter", 32'(iter_count), 32'd0);
`endif
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      d0 = done_cnt;
      repeat (260) @(negedge clk);
      #1;
      chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
      do_start(9, 6);    wait_done("t5_9_6", 1);

      for (int i = 0; i < 1000; i++) begin
         do_start(int'($urandom_range(0, (1 << WIDTH) - 1)),
                  int'($urandom_range(0, (1 << WIDTH) - 1)));
         wait_done("rand", 1);
      end

      chk("gcd_out_stable", 32'(glitch_cnt), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gcd_fsmd_param.md
Name: gcd_fsmd_param

Overview:
Parametrised greatest-common-divisor engine built as a small FSMD: a controller FSM driving a datapath made of two operand registers, an a-less-than-b comparator, one subtractor and an equality test. It accepts an operand pair through a start/ready handshake and computes the GCD by repeated subtraction. It returns the result with a one-cycle done pulse. It replaces the fixed 4-bit comparator-based GCD datapath and is reused wherever a WIDTH-bit GCD is needed.

Parameters:
WIDTH, 8, operand and result width in bits (min 2)
CNT_W, 16, width of the iteration counter (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when ready=1
a_in  input  WIDTH  operand A, captured when start && ready
b_in  input  WIDTH  operand B, captured when start && ready
ready  output  1  high in IDLE; block accepts a new pair
done  output  1  one-cycle pulse; gcd_out valid
gcd_out  output  WIDTH  result; holds until the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, a_reg=b_reg=0, gcd_out=0, done=0, ready=1. Reset during CALC or DONE aborts the operation. No done is produced for the aborted pair.
- States: IDLE, CALC, DONE.
- IDLE: ready=1. If start=1 on an edge, a_reg<=a_in and b_reg<=b_in, then go to CALC. start=0 keeps the block in IDLE.
- CALC: ready=0. Priority order, evaluated each cycle:
  1. If a_reg==0 or b_reg==0: gcd_out<=a_reg|b_reg, go to DONE. This gives gcd(0,x)=x and gcd(0,0)=0.
  2. Else if a_reg==b_reg: gcd_out<=a_reg, go to DONE.
  3. Else if a_reg<b_reg (unsigned): b_reg<=b_reg-a_reg, stay in CALC.
  4. Else: a_reg<=a_reg-b_reg, stay in CALC.
- DONE: done=1 for exactly this one cycle, ready=0. Next state is IDLE unconditionally.
- Latency: with the start edge at cycle 0, done is high at cycle N+2, where N = number of subtract cycles. Back-to-back throughput: a new start is accepted no earlier than cycle N+3.
- start while ready=0 is ignored. Input ports are don't-care outside the accept edge.
- Arithmetic: all unsigned, WIDTH bits. A subtraction never underflows, because the smaller operand is always subtracted from the larger.
- done and ready are registered-state decodes, never combinational on inputs.
- gcd_out changes only on the CALC->DONE transition or on reset.

Optional Feature:
Macro GCD_ITER_COUNT_EN.
- Defined:
  - Adds output port iter_count [CNT_W-1:0].
  - Cleared to 0 on reset and on each accepted start.
  - Increments once per subtract cycle (rules 3 and 4) and saturates at all-ones.
  - Stable and valid when done=1; holds until the next accepted start.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset then start with a_in=12, b_in=18 at cycle 0 -> done at cycle 4, gcd_out=6, iter_count=2. ready low in cycles 1-4, high at cycle 5.
2. a_in=7, b_in=7 -> done at cycle 2, gcd_out=7, iter_count=0. Also a_in=0, b_in=9 -> done at cycle 2, gcd_out=9. Also a_in=0, b_in=0 -> gcd_out=0.
3. WIDTH=8, a_in=255, b_in=1 -> done at cycle 256, gcd_out=1, iter_count=254. Also a_in=128, b_in=96 -> gcd_out=32.
4. Start with 12/18, then pulse start with 5/10 at cycle 2 -> second request ignored, gcd_out=6. A fresh start at cycle 5 with 5/10 -> done at cycle 8, gcd_out=5.
5. Start 255/1, assert rst asynchronously mid-cycle at cycle 50 -> outputs go to reset values immediately, no done pulse. After release, 9/6 -> gcd_out=3.
6. Random regression: 1000 random WIDTH-bit pairs checked against a reference GCD model. Each pair must show exactly one done pulse, and gcd_out must hold stable between done pulses.
